// File: rtl/down_counter_ctrl_if.sv
// Handshake and counter-control bundle for down_counter_ctrl.
// Build option DOWN_COUNTER_CTRL_AUTO_RELOAD_EN adds the auto_reload signal.
interface down_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start_valid;
    logic [WIDTH-1:0] start_value;
    logic             start_ready;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic [7:0]       run_count;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
    logic             auto_reload;

    modport master (
        output start_valid, start_value, pause, abort, count, auto_reload,
        input  start_ready, cnt_load, cnt_load_val, cnt_en, busy, done, run_count
    );

    modport slave (
        input  start_valid, start_value, pause, abort, count, auto_reload,
        output start_ready, cnt_load, cnt_load_val, cnt_en, busy, done, run_count
    );
`else
    modport master (
        output start_valid, start_value, pause, abort, count,
        input  start_ready, cnt_load, cnt_load_val, cnt_en, busy, done, run_count
    );

    modport slave (
        input  start_valid, start_value, pause, abort, count,
        output start_ready, cnt_load, cnt_load_val, cnt_en, busy, done, run_count
    );
`endif
endinterface

// File: rtl/down_counter_ctrl.sv
// Sequencer for a down counter: accepts jobs, loads and enables the counter, reports completion.
// Define DOWN_COUNTER_CTRL_AUTO_RELOAD_EN to rerun the captured value while auto_reload is high.
module down_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    down_counter_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic [7:0]       run_count_reg, run_count_next;
    logic             reload_req;
    logic             start_ready_c, cnt_load_c, cnt_en_c, busy_c, done_c;

`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
    assign reload_req = bus.auto_reload && (cap_reg != '0);
`else
    assign reload_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cap_reg       <= '0;
            run_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            cap_reg       <= cap_next;
            run_count_reg <= run_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cap_next       = cap_reg;
        run_count_next = run_count_reg;
        start_ready_c  = 1'b0;
        cnt_load_c     = 1'b0;
        cnt_en_c       = 1'b0;
        busy_c         = 1'b1;
        done_c         = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready_c = 1'b1;
                busy_c        = 1'b0;
                if (bus.start_valid) begin
                    cap_next   = bus.start_value;
                    // A zero-length job never touches the counter
                    state_next = (bus.start_value != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                cnt_load_c = 1'b1;
                state_next = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    // Gate on zero so the counter never wraps to all-ones
                    cnt_en_c = !bus.pause && (bus.count != '0);
                    if (bus.count == '0)
                        state_next = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (run_count_reg != 8'hFF)
                    run_count_next = run_count_reg + 8'd1;
                state_next = reload_req ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.start_ready  = start_ready_c;
    assign bus.cnt_load     = cnt_load_c;
    assign bus.cnt_load_val = cap_reg;
    assign bus.cnt_en       = cnt_en_c;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
    assign bus.run_count    = run_count_reg;
endmodule

// File: tb/tb_down_counter_ctrl.sv
// Bench for down_counter_ctrl with a behavioural counter and an arithmetic timing model.
module tb_down_counter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rc = 8'd0;
    logic [3:0] cnt_q;

    down_counter_ctrl_if #(.WIDTH(4)) bus ();

    down_counter_ctrl #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The counter datapath the controller steers
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt_q <= 4'd0;
        else if (bus.cnt_load) cnt_q <= bus.cnt_load_val;
        else if (bus.cnt_en)   cnt_q <= cnt_q - 4'd1;
    end
    assign bus.count = cnt_q;

    task automatic idle_inputs();
        bus.start_valid = 1'b0;
        bus.start_value = 4'd0;
        bus.pause       = 1'b0;
        bus.abort       = 1'b0;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        bus.auto_reload = 1'b0;
`endif
    endtask

    // Runs one job; abort_req: -1 none, 0 random offset, >0 fixed offset from accept
    task automatic run_job(input logic [3:0] n, input logic [127:0] pmask, input int abort_req);
        int exp_cnt [128];
        int d, t, rem, a, last;
        bit aborted, live;
        logic [7:0] rc_after, exp_run;
        logic exp_bit;
        for (int i = 0; i < 128; i++) exp_cnt[i] = 0;
        if (n == 4'd0) begin
            d = 1;
        end else begin
            t = 2;
            rem = int'(n);
            while (rem != 0) begin
                exp_cnt[t] = rem;
                if (!pmask[t]) rem--;
                t++;
            end
            d = t + 1;
        end
        a = abort_req;
        if (n == 4'd0) a = -1;
        else if (a == 0) a = int'($urandom_range(d - 1, 1));
        aborted  = (a >= 1) && (a <= d - 1);
        rc_after = aborted ? exp_rc : ((exp_rc == 8'hFF) ? 8'hFF : exp_rc + 8'd1);
        last     = aborted ? a + 1 : d + 1;

        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.start_value = n;
        bus.pause       = 1'($urandom);
        bus.abort       = 1'($urandom);
        @(negedge clk);
        checks++;
        if (bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready n=%0d: got %b expected 1", n, bus.start_ready);
        end
        for (t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            bus.start_valid = (t < last) ? 1'($urandom) : 1'b0;
            bus.start_value = 4'($urandom);
            bus.pause       = pmask[t];
            bus.abort       = aborted ? (t == a) : ((t == d) ? 1'($urandom) : 1'b0);
            @(negedge clk);
            live = !aborted || (t <= a);

            exp_bit = !aborted && (t == d);
            checks++;
            if (bus.done !== exp_bit) begin
                errors++;
                $display("FAIL done n=%0d t=%0d: got %b expected %b", n, t, bus.done, exp_bit);
            end
            exp_bit = (t == last);
            checks++;
            if (bus.start_ready !== exp_bit || bus.busy !== !exp_bit) begin
                errors++;
                $display("FAIL ready_busy n=%0d t=%0d: got %b/%b expected %b/%b",
                         n, t, bus.start_ready, bus.busy, exp_bit, !exp_bit);
            end
            exp_bit = (n != 4'd0) && (t == 1);
            checks++;
            if (bus.cnt_load !== exp_bit) begin
                errors++;
                $display("FAIL cnt_load n=%0d t=%0d: got %b expected %b", n, t, bus.cnt_load, exp_bit);
            end
            checks++;
            if (bus.cnt_load_val !== n) begin
                errors++;
                $display("FAIL cnt_load_val n=%0d t=%0d: got %0d expected %0d", n, t, bus.cnt_load_val, n);
            end
            exp_bit = live && (t >= 2) && (t < d) && (exp_cnt[t] != 0) && !pmask[t]
                      && !(aborted && t == a);
            checks++;
            if (bus.cnt_en !== exp_bit) begin
                errors++;
                $display("FAIL cnt_en n=%0d t=%0d: got %b expected %b", n, t, bus.cnt_en, exp_bit);
            end
            if (live && t >= 2 && t <= d) begin
                checks++;
                if (int'(bus.count) != exp_cnt[t]) begin
                    errors++;
                    $display("FAIL count n=%0d t=%0d: got %0d expected %0d", n, t, bus.count, exp_cnt[t]);
                end
            end
            exp_run = (t == last) ? rc_after : exp_rc;
            checks++;
            if (bus.run_count !== exp_run) begin
                errors++;
                $display("FAIL run_count n=%0d t=%0d: got %0d expected %0d", n, t, bus.run_count, exp_run);
            end
        end
        exp_rc = rc_after;
        idle_inputs();
        $display("job n=%0d done_at=%0d abort_at=%0d run_count=%0d", n, aborted ? -1 : d,
                 aborted ? a : -1, exp_rc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready=%b busy=%b done=%b expected 1/0/0",
                     bus.start_ready, bus.busy, bus.done);
        end
        checks++;
        if (bus.cnt_load !== 1'b0 || bus.cnt_en !== 1'b0 || bus.cnt_load_val !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got load=%b en=%b val=%0d expected 0/0/0",
                     bus.cnt_load, bus.cnt_en, bus.cnt_load_val);
        end
        checks++;
        if (bus.run_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_run_count: got %0d expected 0", bus.run_count);
        end
        rst = 1'b0;
        exp_rc = 8'd0;
        $display("reset released");
    endtask

    task automatic test_basic();
        run_job(4'd5, '0, -1);
        run_job(4'd1, '0, -1);
    endtask

    task automatic test_zero();
        run_job(4'd0, '0, -1);
    endtask

    task automatic test_pause();
        logic [127:0] pm;
        pm = '0;
        pm[4] = 1'b1; pm[5] = 1'b1; pm[6] = 1'b1;
        run_job(4'd15, pm, -1);
    endtask

    task automatic test_abort();
        run_job(4'd8, '0, 7);
        run_job(4'd4, '0, 1);
    endtask

    task automatic test_rst_midjob();
        bit hit;
        hit = 1'b0;
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.start_value = 4'd12;
        @(posedge clk); #1;
        idle_inputs();
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.count == 4'd7) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_wait_count7: got no count=7 expected count=7 within 40 cycles");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt_en !== 1'b0
            || bus.cnt_load !== 1'b0 || bus.cnt_load_val !== 4'd0 || bus.run_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_midjob: got ready=%b busy=%b done=%b en=%b load=%b val=%0d rc=%0d expected 1/0/0/0/0/0/0",
                     bus.start_ready, bus.busy, bus.done, bus.cnt_en, bus.cnt_load,
                     bus.cnt_load_val, bus.run_count);
        end
        exp_rc = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-job at count=7");
    endtask

    task automatic test_random();
        logic [127:0] pm;
        int pct;
        for (int j = 0; j < 20; j++) begin
            pct = int'($urandom_range(50, 0));
            pm = '0;
            for (int i = 0; i < 60; i++) pm[i] = ($urandom_range(99, 0) < pct);
            run_job(4'($urandom), pm, ($urandom_range(3, 0) == 0) ? 0 : -1);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 256; j++) run_job(4'd1, '0, -1);
        checks++;
        if (bus.run_count !== 8'hFF) begin
            errors++;
            $display("FAIL saturate: got %0d expected 255", bus.run_count);
        end
    endtask

`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [7:0] base, exp_run;
        int k;
        base = exp_rc;
        @(posedge clk); #1;
        bus.auto_reload = 1'b1;
        bus.start_valid = 1'b1;
        bus.start_value = 4'd2;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            bus.start_valid = 1'($urandom);
            bus.start_value = 4'($urandom);
            bus.abort       = (t == 16);
            if (t >= 17) bus.auto_reload = 1'b0;
            if (t >= 17) bus.start_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.done !== (t <= 16 && t % 5 == 0)) begin
                errors++;
                $display("FAIL reload_done t=%0d: got %b expected %b", t, bus.done, (t <= 16 && t % 5 == 0));
            end
            checks++;
            if (bus.start_ready !== (t >= 17)) begin
                errors++;
                $display("FAIL reload_ready t=%0d: got %b expected %b", t, bus.start_ready, (t >= 17));
            end
            k = (t > 15) ? 3 : (t - 1) / 5;
            exp_run = (int'(base) + k > 255) ? 8'hFF : base + 8'(k);
            checks++;
            if (bus.run_count !== exp_run) begin
                errors++;
                $display("FAIL reload_run_count t=%0d: got %0d expected %0d", t, bus.run_count, exp_run);
            end
        end
        exp_rc = (int'(base) + 3 > 255) ? 8'hFF : base + 8'd3;
        idle_inputs();
        $display("auto reload value=2 three runs then abort, run_count=%0d", exp_rc);
    endtask
`endif

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_pause();
        test_abort();
        test_rst_midjob();
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
